execution_stage: RTL and testbench

Execute stage of the five-stage ARM-subset pipeline. It sits between the ID/EXE pipeline register and the EXE/MEM register. It forms the second ALU operand (Val2) from an immediate, a shifted register, or a memory offset. It computes the ALU result and the NZCV flags, and produces the branch target. Flags go to the status register, which latches them when the S bit is set.

---
 rtl/arm_pkg.sv | 25 ++
 rtl/execution_stage_if.sv | 30 +++
 rtl/alu.sv | 50 +++++
 rtl/val2_generator.sv | 41 ++++
 rtl/execution_stage.sv | 37 +++
 tb/tb_execution_stage.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/arm_pkg.sv
// Shared constants for the ARM-subset pipeline: ALU command codes,
// shifter types and status-flag bit positions.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/execution_stage_if.sv
// Operand/result bundle between the ID/EXE register and the execute stage.
interface execution_stage_if;

    logic [3:0]  executionCommand;
    logic        memoryReadEnabled;
    logic        memoryWriteEnabled;
    logic [31:0] pc;
    logic [31:0] valRn;
    logic [31:0] valRm;
    logic        imm;
    logic [11:0] shiftOperand;
    logic [23:0] imm24;
    logic [3:0]  status;
    logic [31:0] aluResult;
    logic [31:0] branchAddress;
    logic [3:0]  statusOut;

    modport master (
        output executionCommand, memoryReadEnabled, memoryWriteEnabled, pc,
               valRn, valRm, imm, shiftOperand, imm24, status,
        input  aluResult, branchAddress, statusOut
    );

    modport slave (
        input  executionCommand, memoryReadEnabled, memoryWriteEnabled, pc,
               valRn, valRm, imm, shiftOperand, imm24, status,
        output aluResult, branchAddress, statusOut
    );

endinterface

// File: rtl/alu.sv
// ALU with NZCV generation; undefined commands yield 0 and keep flags.
module alu
    import arm_pkg::*;
(
    input  logic [3:0]  command,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [3:0]  status,
    output logic [31:0] result,
    output logic [3:0]  status_next
);

    logic [32:0] wide;
    logic        valid;

    always_comb begin
        result      = 32'b0;
        status_next = status;
        wide        = 33'b0;
        valid       = 1'b1;
        case (command)
            EXE_MOV: result = val2;
            EXE_MVN: result = ~val2;
            EXE_ADD, EXE_ADC: begin
                wide   = {1'b0, val1} + {1'b0, val2}
                       + {32'b0, (command == EXE_ADC) & status[FLAG_C]};
                result = wide[31:0];
                status_next[FLAG_C] = wide[32];
                status_next[FLAG_V] = (val1[31] == val2[31]) && (result[31] != val1[31]);
            end
            EXE_SUB, EXE_SBC: begin
                // bit 32 of the difference is the borrow; C is its inverse
                wide   = {1'b0, val1} - {1'b0, val2}
                       - {32'b0, (command == EXE_SBC) & ~status[FLAG_C]};
                result = wide[31:0];
                status_next[FLAG_C] = ~wide[32];
                status_next[FLAG_V] = (val1[31] != val2[31]) && (result[31] != val1[31]);
            end
            EXE_AND: result = val1 & val2;
            EXE_ORR: result = val1 | val2;
            EXE_EOR: result = val1 ^ val2;
            default: valid = 1'b0;
        endcase
        if (valid) begin
            status_next[FLAG_N] = result[31];
            status_next[FLAG_Z] = (result == 32'b0);
        end
    end

endmodule

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated immediate, or shifted Rm.
module val2_generator
    import arm_pkg::*;
(
    input  logic        mem_access,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);

    logic [31:0] imm_ext;
    logic [63:0] imm_rot;
    logic [63:0] rm_rot;
    logic [4:0]  shift_amt;
    logic [1:0]  shift_type;

    assign imm_ext    = {24'b0, shift_operand[7:0]};
    assign imm_rot    = {imm_ext, imm_ext} >> {shift_operand[11:8], 1'b0};
    assign shift_amt  = shift_operand[11:7];
    assign shift_type = shift_operand[6:5];
    assign rm_rot     = {val_rm, val_rm} >> shift_amt;

    always_comb begin
        val2 = val_rm;
        if (mem_access) begin
            // load/store offsets are plain 12-bit values, never rotated
            val2 = {20'b0, shift_operand};
        end else if (imm) begin
            val2 = imm_rot[31:0];
        end else begin
            case (shift_type)
                LSL:     val2 = val_rm << shift_amt;
                LSR:     val2 = val_rm >> shift_amt;
                ASR:     val2 = $signed(val_rm) >>> shift_amt;
                default: val2 = rm_rot[31:0];
            endcase
        end
    end

endmodule

// File: rtl/execution_stage.sv
// Execute stage: Val2 formation, ALU/flags and branch target, all combinational.
module execution_stage
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    execution_stage_if.slave  bus
);

    logic [31:0] val2;
    logic [31:0] branch_offset;
    logic        unused_ok;

    // pipeline registers live on either side; clk/rst are here for uniformity
    assign unused_ok = clk ^ rst;

    val2_generator u_val2 (
        .mem_access    (bus.memoryReadEnabled | bus.memoryWriteEnabled),
        .imm           (bus.imm),
        .shift_operand (bus.shiftOperand),
        .val_rm        (bus.valRm),
        .val2          (val2)
    );

    alu u_alu (
        .command     (bus.executionCommand),
        .val1        (bus.valRn),
        .val2        (val2),
        .status      (bus.status),
        .result      (bus.aluResult),
        .status_next (bus.statusOut)
    );

    assign branch_offset     = {{6{bus.imm24[23]}}, bus.imm24, 2'b00};
    assign bus.branchAddress = bus.pc + branch_offset;

endmodule

// File: tb/tb_execution_stage.sv
// Directed self-checking bench for execution_stage.
module tb_execution_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    execution_stage_if bus ();

    execution_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] cmd, input logic mr, input logic mw,
                         input logic [31:0] pc, input logic [31:0] rn,
                         input logic [31:0] rm, input logic im,
                         input logic [11:0] so, input logic [23:0] i24,
                         input logic [3:0] st);
        @(posedge clk);
        bus.executionCommand   = cmd;
        bus.memoryReadEnabled  = mr;
        bus.memoryWriteEnabled = mw;
        bus.pc                 = pc;
        bus.valRn              = rn;
        bus.valRm              = rm;
        bus.imm                = im;
        bus.shiftOperand       = so;
        bus.imm24              = i24;
        bus.status             = st;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 12'h0, 24'h0, 4'h0);
        checks++;
        if (bus.aluResult !== 32'h0) begin
            errors++; $display("FAIL reset_alu got=%h exp=%h", bus.aluResult, 32'h0);
        end
        checks++;
        if (bus.branchAddress !== 32'h0) begin
            errors++; $display("FAIL reset_branch got=%h exp=%h", bus.branchAddress, 32'h0);
        end
        checks++;
        if (bus.statusOut !== 4'h0) begin
            errors++; $display("FAIL reset_status got=%b exp=%b", bus.statusOut, 4'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_move();
        drive(4'b0001, 0, 0, 0, 0, 0, 1, 12'h2FF, 0, 4'b0011);
        checks++;
        if (bus.aluResult !== 32'hF000000F) begin
            errors++; $display("FAIL mov_imm_res got=%h exp=%h", bus.aluResult, 32'hF000000F);
        end
        checks++;
        if (bus.statusOut !== 4'b1011) begin
            errors++; $display("FAIL mov_imm_flags got=%b exp=%b", bus.statusOut, 4'b1011);
        end
        drive(4'b1001, 0, 0, 0, 0, 0, 1, 12'h000, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'hFFFFFFFF || bus.statusOut !== 4'b1000) begin
            errors++; $display("FAIL mvn got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'hFFFFFFFF, 4'b1000);
        end
    endtask

    task automatic test_shifter();
        drive(4'b0001, 0, 0, 0, 0, 32'h80000001, 0, 12'h0C0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'hC0000000) begin
            errors++; $display("FAIL asr1 got=%h exp=%h", bus.aluResult, 32'hC0000000);
        end
        drive(4'b0001, 0, 0, 0, 0, 32'h1, 0, 12'h200, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h10) begin
            errors++; $display("FAIL lsl4 got=%h exp=%h", bus.aluResult, 32'h10);
        end
        drive(4'b0001, 0, 0, 0, 0, 32'h80000000, 0, 12'hFA0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h1) begin
            errors++; $display("FAIL lsr31 got=%h exp=%h", bus.aluResult, 32'h1);
        end
        drive(4'b0001, 0, 0, 0, 0, 32'h000000AB, 0, 12'h460, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'hAB000000 || bus.statusOut !== 4'b1000) begin
            errors++; $display("FAIL ror8 got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'hAB000000, 4'b1000);
        end
        drive(4'b0001, 0, 0, 0, 0, 32'h12345678, 0, 12'h060, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h12345678) begin
            errors++; $display("FAIL ror0 got=%h exp=%h", bus.aluResult, 32'h12345678);
        end
    endtask

    task automatic test_arith();
        drive(4'b0010, 0, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 12'h0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h80000000 || bus.statusOut !== 4'b1001) begin
            errors++; $display("FAIL add_ovf got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h80000000, 4'b1001);
        end
        drive(4'b0010, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 12'h0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h0 || bus.statusOut !== 4'b0110) begin
            errors++; $display("FAIL add_carry got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h0, 4'b0110);
        end
        drive(4'b0100, 0, 0, 0, 32'h5, 32'h5, 0, 12'h0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h0 || bus.statusOut !== 4'b0110) begin
            errors++; $display("FAIL sub_zero got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h0, 4'b0110);
        end
        drive(4'b0100, 0, 0, 0, 32'h0, 32'h1, 0, 12'h0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'hFFFFFFFF || bus.statusOut !== 4'b1000) begin
            errors++; $display("FAIL sub_borrow got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'hFFFFFFFF, 4'b1000);
        end
        drive(4'b0100, 0, 0, 0, 32'h80000000, 32'h1, 0, 12'h0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h7FFFFFFF || bus.statusOut !== 4'b0011) begin
            errors++; $display("FAIL sub_ovf got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h7FFFFFFF, 4'b0011);
        end
    endtask

    task automatic test_carry_in();
        drive(4'b0011, 0, 0, 0, 32'h1, 0, 1, 12'h001, 0, 4'b0010);
        checks++;
        if (bus.aluResult !== 32'h3 || bus.statusOut !== 4'b0000) begin
            errors++; $display("FAIL adc_c1 got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h3, 4'b0000);
        end
        drive(4'b0011, 0, 0, 0, 32'h1, 0, 1, 12'h001, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h2) begin
            errors++; $display("FAIL adc_c0 got=%h exp=%h", bus.aluResult, 32'h2);
        end
        drive(4'b0101, 0, 0, 0, 32'h5, 0, 1, 12'h003, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h1 || bus.statusOut !== 4'b0010) begin
            errors++; $display("FAIL sbc_c0 got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h1, 4'b0010);
        end
        drive(4'b0101, 0, 0, 0, 32'h5, 0, 1, 12'h003, 0, 4'b0010);
        checks++;
        if (bus.aluResult !== 32'h2) begin
            errors++; $display("FAIL sbc_c1 got=%h exp=%h", bus.aluResult, 32'h2);
        end
    endtask

    task automatic test_logic();
        drive(4'b0110, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 12'h0, 0, 4'b0011);
        checks++;
        if (bus.aluResult !== 32'hF000F000 || bus.statusOut !== 4'b1011) begin
            errors++; $display("FAIL and got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'hF000F000, 4'b1011);
        end
        drive(4'b0111, 0, 0, 0, 32'h0000F0F0, 32'h00000F0F, 0, 12'h0, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h0000FFFF || bus.statusOut !== 4'b0000) begin
            errors++; $display("FAIL orr got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h0000FFFF, 4'b0000);
        end
        drive(4'b1000, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 12'h0, 0, 4'b0001);
        checks++;
        if (bus.aluResult !== 32'h0 || bus.statusOut !== 4'b0101) begin
            errors++; $display("FAIL eor got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h0, 4'b0101);
        end
        drive(4'b1111, 0, 0, 0, 32'h12, 32'h34, 0, 12'h0, 0, 4'b1010);
        checks++;
        if (bus.aluResult !== 32'h0 || bus.statusOut !== 4'b1010) begin
            errors++; $display("FAIL undef_cmd got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h0, 4'b1010);
        end
    endtask

    task automatic test_memory();
        drive(4'b0010, 0, 1, 0, 32'h100, 32'hDEAD, 1, 12'h804, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h904 || bus.statusOut !== 4'b0000) begin
            errors++; $display("FAIL str_addr got=%h/%b exp=%h/%b", bus.aluResult, bus.statusOut, 32'h904, 4'b0000);
        end
        drive(4'b0010, 1, 0, 0, 32'h1000, 32'hFFFFFFFF, 0, 12'hFFF, 0, 4'b0000);
        checks++;
        if (bus.aluResult !== 32'h1FFF) begin
            errors++; $display("FAIL ldr_addr got=%h exp=%h", bus.aluResult, 32'h1FFF);
        end
    endtask

    task automatic test_branch();
        drive(4'b0000, 0, 0, 32'h20, 0, 0, 0, 12'h0, 24'hFFFFFE, 4'b0000);
        checks++;
        if (bus.branchAddress !== 32'h18) begin
            errors++; $display("FAIL br_back got=%h exp=%h", bus.branchAddress, 32'h18);
        end
        drive(4'b0010, 0, 0, 32'h100, 1, 1, 0, 12'h0, 24'h000010, 4'b0000);
        checks++;
        if (bus.branchAddress !== 32'h140) begin
            errors++; $display("FAIL br_fwd got=%h exp=%h", bus.branchAddress, 32'h140);
        end
        drive(4'b0000, 0, 0, 32'h04000000, 0, 0, 0, 12'h0, 24'h800000, 4'b0000);
        checks++;
        if (bus.branchAddress !== 32'h02000000) begin
            errors++; $display("FAIL br_min got=%h exp=%h", bus.branchAddress, 32'h02000000);
        end
        drive(4'b0000, 0, 0, 32'h0, 0, 0, 0, 12'h0, 24'hFFFFFF, 4'b0000);
        checks++;
        if (bus.branchAddress !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL br_wrap got=%h exp=%h", bus.branchAddress, 32'hFFFFFFFC);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_shifter();
        test_arith();
        test_carry_in();
        test_logic();
        test_memory();
        test_branch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
